// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-requester data-memory arbiter.
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN (misaligned-access error).
package dmem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef logic req_id_t;

    function automatic logic [NUM_REQ-1:0] id_onehot(req_id_t id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the pointer register is held by the caller.
// Part of dmem_arbiter (see DMEM_ARB_ALIGN_CHK_EN in the top).
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            ptr,
    output logic               valid,
    output req_id_t            win
);

    assign valid = |req;
    assign win   = (req[0] & req[1]) ? ptr : req_id_t'(req[1]);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin controller for the single-port synchronous dmem.
// Define DMEM_ARB_ALIGN_CHK_EN to reject word-misaligned accesses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0]              we_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              done_o,
    output logic [NUM_REQ-1:0][DATA_W-1:0]  rdata_o,
    output logic [NUM_REQ-1:0]              err_o,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_a,
    output logic [DATA_W-1:0]               mem_wd,
    input  logic [DATA_W-1:0]               mem_rd
);

    arb_state_t         state;
    req_id_t            ptr;
    req_id_t            id;
    req_id_t            win;
    logic               valid;
    logic               bad;
    logic [NUM_REQ-1:0] misal;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            misal[r] = addr_i[r][1:0] != 2'b00;
        end
    end
`else
    assign misal = '0;
`endif

    rr_arb2 u_arb (
        .req   (req_i),
        .ptr   (ptr),
        .valid (valid),
        .win   (win)
    );

    // mem_a/mem_wd double as the command registers for the access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            id      <= 1'b0;
            bad     <= 1'b0;
            gnt_o   <= '0;
            done_o  <= '0;
            err_o   <= '0;
            rdata_o <= '0;
            mem_we  <= 1'b0;
            mem_a   <= '0;
            mem_wd  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_o <= '0;
                    err_o  <= '0;
                    if (valid) begin
                        state  <= ISSUE;
                        id     <= win;
                        ptr    <= ~win;
                        bad    <= misal[win];
                        gnt_o  <= id_onehot(win);
                        mem_we <= we_i[win] & ~misal[win];
                        mem_a  <= addr_i[win];
                        mem_wd <= wdata_i[win];
                    end
                end
                ISSUE: begin
                    gnt_o  <= '0;
                    mem_we <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    state  <= IDLE;
                    done_o <= id_onehot(id);
                    err_o  <= bad ? id_onehot(id) : '0;
                    if (!bad) begin
                        rdata_o[id] <= mem_rd;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem model.
// Build with +define+DMEM_ARB_ALIGN_CHK_EN to add the misalignment case.
module tb_dmem_arbiter;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][7:0]  addr;
    logic [1:0][31:0] wdata;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [1:0][31:0] rdata;
    logic [1:0]       err;
    logic             mem_we;
    logic [7:0]       mem_a;
    logic [31:0]      mem_wd;
    logic [31:0]      mem_rd;

    logic [31:0] mem [64];
    logic        pl_we;
    logic [5:0]  pl_a;
    logic [31:0] pl_d;

    int n_run;
    int n_fail;

    dmem_arbiter #(
        .ADDR_W (8),
        .DATA_W (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .gnt_o   (gnt),
        .done_o  (done),
        .rdata_o (rdata),
        .err_o   (err),
        .mem_we  (mem_we),
        .mem_a   (mem_a),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port synchronous memory, read-before-write
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_a] <= pl_d;
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
        mem_rd <= mem[mem_a[7:2]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rid;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [1:0] oh(input logic r);
        return r ? 2'b10 : 2'b01;
    endfunction

    task automatic apply(input vec_t v);
        req[v.rid]   = 1'b1;
        we[v.rid]    = v.we;
        addr[v.rid]  = v.addr;
        wdata[v.rid] = v.wd;
        tick();
        chk("gnt", 64'(gnt), 64'(oh(v.rid)));
        chk("issue_we", 64'(mem_we), 64'(v.we));
        chk("issue_a", 64'(mem_a), 64'(v.addr));
        if (v.we) chk("issue_wd", 64'(mem_wd), 64'(v.wd));
        req[v.rid] = 1'b0;
        tick();
        chk("wait_we", 64'(mem_we), 64'd0);
        chk("wait_gnt", 64'(gnt), 64'd0);
        tick();
        chk("done", 64'(done), 64'(oh(v.rid)));
        chk("err", 64'(err), 64'd0);
        if (!v.we) chk("rdata", 64'(rdata[v.rid]), 64'(v.exp));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] eg;
        logic       any_done;
        n_run  = 0;
        n_fail = 0;
        req    = '0;
        we     = '0;
        addr   = '0;
        wdata  = '0;
        rst_n  = 1'b0;
        pl_we  = 1'b1;
        pl_a   = 6'h04;
        pl_d   = 32'h1234_5678;

        vt[0] = '{1'b0, 1'b0, 8'h10, 32'h0, 32'h1234_5678};
        vt[1] = '{1'b1, 1'b1, 8'h20, 32'hDEAD_BEEF, 32'h0};
        vt[2] = '{1'b1, 1'b0, 8'h20, 32'h0, 32'hDEAD_BEEF};
        vt[3] = '{1'b0, 1'b1, 8'h3C, 32'hA5A5_0001, 32'h0};
        vt[4] = '{1'b0, 1'b0, 8'h3C, 32'h0, 32'hA5A5_0001};
        vt[5] = '{1'b1, 1'b0, 8'h10, 32'h0, 32'h1234_5678};

        tick();
        pl_we = 1'b0;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mem", 64'({mem_we, mem_a, mem_wd}), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            apply(vt[i]);
        end

        // continuous contention from reset: 0,1,0,1 every 3 cycles
        do_reset();
        req   = 2'b11;
        we    = 2'b00;
        addr  = {8'h20, 8'h10};
        for (int c = 1; c <= 12; c++) begin
            tick();
            eg = (c == 1 || c == 7) ? 2'b01 :
                 (c == 4 || c == 10) ? 2'b10 : 2'b00;
            chk($sformatf("cont_gnt_c%0d", c), 64'(gnt), 64'(eg));
        end
        req = '0;
        tick();

        // held loser: pointer at 1 after a req0 grant
        apply(vt[0]);
        req   = 2'b11;
        we    = 2'b01;
        addr  = {8'h10, 8'h30};
        wdata = {32'h0, 32'h1111_2222};
        tick();
        chk("hl_gnt1", 64'(gnt), 64'b10);
        chk("hl_a1", 64'(mem_a), 64'h10);
        req[1] = 1'b0;
        tick();
        tick();
        chk("hl_done1", 64'(done), 64'b10);
        chk("hl_rd1", 64'(rdata[1]), 64'h1234_5678);
        tick();
        chk("hl_gnt0", 64'(gnt), 64'b01);
        chk("hl_cmd0", 64'({mem_we, mem_a, mem_wd}),
            64'({1'b1, 8'h30, 32'h1111_2222}));
        req[0] = 1'b0;
        tick();
        tick();
        chk("hl_done0", 64'(done), 64'b01);
        apply('{1'b0, 1'b0, 8'h30, 32'h0, 32'h1111_2222});

        // reset during WAIT aborts the access
        req[0]  = 1'b1;
        we[0]   = 1'b0;
        addr[0] = 8'h10;
        tick();
        req[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_gnt", 64'(gnt), 64'd0);
        chk("rw_done", 64'(done), 64'd0);
        chk("rw_mem", 64'({mem_we, mem_a, mem_wd}), 64'd0);
        chk("rw_rdata", 64'(rdata), 64'd0);
        @(negedge clk);
        tick();
        rst_n    = 1'b1;
        any_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            any_done |= |done;
        end
        chk("rw_no_done", 64'(any_done), 64'd0);
        req  = 2'b11;
        we   = 2'b00;
        addr = {8'h20, 8'h10};
        tick();
        chk("rw_gnt0", 64'(gnt), 64'b01);
        req[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("rw_gnt1", 64'(gnt), 64'b10);
        req[1] = 1'b0;
        tick();
        tick();

`ifdef DMEM_ARB_ALIGN_CHK_EN
        req[1]   = 1'b1;
        we[1]    = 1'b1;
        addr[1]  = 8'h21;
        wdata[1] = 32'hCAFE_F00D;
        tick();
        chk("al_gnt", 64'(gnt), 64'b10);
        chk("al_we_issue", 64'(mem_we), 64'd0);
        req[1] = 1'b0;
        tick();
        chk("al_we_wait", 64'(mem_we), 64'd0);
        tick();
        chk("al_done", 64'(done), 64'b10);
        chk("al_err", 64'(err), 64'b10);
        chk("al_rdata", 64'(rdata[1]), 64'hDEAD_BEEF);
        apply(vt[2]);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
